// File: rtl/mem_to_io.sv
// Bridge between the LC-3 CPU data bus and the async SRAM data bus. One address
// is memory-mapped: reads of it return the switches, writes load a 16-bit hex display register.
module mem_to_io #(
    parameter int          ADDR_W  = 20,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] A,
    input  logic              CE,
    input  logic              UB,
    input  logic              LB,
    input  logic              OE,
    input  logic              WE,
    input  logic [15:0]       Switches,
    inout  wire  [15:0]       Data_CPU,
    inout  wire  [15:0]       Data_Mem,
    output logic [3:0]        HEX0,
    output logic [3:0]        HEX1,
    output logic [3:0]        HEX2,
    output logic [3:0]        HEX3
);

    logic        io_hit;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] rd_data;
    logic [15:0] hex_q;
    logic        unused_addr_hi;

    // Only the low 16 address bits take part in the IO decode.
    assign io_hit         = (A[15:0] == IO_ADDR);
    assign unused_addr_hi = ^A[ADDR_W-1:16];

    // A write (WE=0) always wins over OE, so Data_CPU is never driven while the CPU drives it.
    assign wr_en   = !CE && !WE;
    assign rd_en   = !CE && !OE && WE;
    assign rd_data = io_hit ? Switches : Data_Mem;

    assign Data_CPU = rd_en ? rd_data  : 16'hzzzz;
    assign Data_Mem = wr_en ? Data_CPU : 16'hzzzz;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            hex_q <= 16'h0000;
        end else if (wr_en && io_hit) begin
            if (!LB) hex_q[7:0]  <= Data_CPU[7:0];
            if (!UB) hex_q[15:8] <= Data_CPU[15:8];
        end
    end

    assign HEX0 = hex_q[3:0];
    assign HEX1 = hex_q[7:4];
    assign HEX2 = hex_q[11:8];
    assign HEX3 = hex_q[15:12];

endmodule

// File: tb/tb_mem_to_io.sv
// Directed bench for mem_to_io: bus routing and the byte-enabled hex display register,
// with expected values queued at stimulus time and popped at each check point.
module tb_mem_to_io;

    logic        clk;
    logic        reset;
    logic [19:0] a;
    logic        ce, ub, lb, oe, we;
    logic [15:0] switches;
    logic        cpu_drv_en, mem_drv_en;
    logic [15:0] cpu_drv, mem_drv;
    wire  [15:0] data_cpu;
    wire  [15:0] data_mem;
    logic [3:0]  hex0, hex1, hex2, hex3;

    logic [15:0] exp_q[$];
    logic [15:0] hex_model;
    int          vectors;
    int          miscompares;

    assign data_cpu = cpu_drv_en ? cpu_drv : 16'hzzzz;
    assign data_mem = mem_drv_en ? mem_drv : 16'hzzzz;

    mem_to_io #(.ADDR_W(20), .IO_ADDR(16'hFFFF)) dut (
        .Clk      (clk),
        .Reset    (reset),
        .A        (a),
        .CE       (ce),
        .UB       (ub),
        .LB       (lb),
        .OE       (oe),
        .WE       (we),
        .Switches (switches),
        .Data_CPU (data_cpu),
        .Data_Mem (data_mem),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks: everything changes on the falling edge
    task automatic drive_bus(input logic ce_v, input logic oe_v, input logic we_v,
                             input logic ub_v, input logic lb_v, input logic [19:0] a_v);
        @(negedge clk);
        ce = ce_v; oe = oe_v; we = we_v; ub = ub_v; lb = lb_v; a = a_v;
        #1;
    endtask

    task automatic cpu_drive(input logic en, input logic [15:0] v);
        cpu_drv_en = en;
        cpu_drv    = v;
    endtask

    task automatic mem_drive(input logic en, input logic [15:0] v);
        mem_drv_en = en;
        mem_drv    = v;
    endtask

    // scoreboard: pop the next expectation and compare
    task automatic check(input string tag, input logic [15:0] observed);
        logic [15:0] expected;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed=%h, expected queue empty", tag, observed);
        end else begin
            expected = exp_q.pop_front();
            assert (observed === expected) else begin
                miscompares++;
                $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
            end
        end
    endtask

    function automatic logic [15:0] hex_obs();
        return {hex3, hex2, hex1, hex0};
    endfunction

    // clock one edge, then check the display against the model
    task automatic clock_and_check_hex(input string tag);
        exp_q.push_back(hex_model);
        @(posedge clk);
        #1;
        check(tag, hex_obs());
    endtask

    // display model update for an IO write with byte enables
    task automatic model_write(input logic ub_v, input logic lb_v, input logic [15:0] d);
        if (!lb_v) hex_model[7:0]  = d[7:0];
        if (!ub_v) hex_model[15:8] = d[15:8];
    endtask

    initial begin
        logic        r_ub, r_lb, r_hit;
        logic [15:0] r_d;
        logic [19:0] r_a;

        vectors = 0; miscompares = 0;
        reset = 1'b1; ce = 1'b1; oe = 1'b1; we = 1'b1; ub = 1'b1; lb = 1'b1;
        a = 20'h0; switches = 16'hABCD;
        cpu_drive(1'b0, 16'h0); mem_drive(1'b0, 16'h0);

        // reset overrides a simultaneous IO write; bus path still live during reset
        @(negedge clk);
        reset = 1'b0;
        cpu_drive(1'b1, 16'h1234);
        drive_bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h0FFFF);
        exp_q.push_back(16'h1234);
        check("reset_mem_bus", data_mem);
        hex_model = 16'h0000;
        clock_and_check_hex("reset_hex");

        // reads: IO hit returns switches, miss returns SRAM data
        @(negedge clk);
        reset = 1'b1;
        cpu_drive(1'b0, 16'h0);
        mem_drive(1'b1, 16'h5555);
        drive_bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0FFFF);
        exp_q.push_back(16'hABCD);
        check("read_io", data_cpu);
        exp_q.push_back(16'h5555);
        check("read_io_mem_undriven", data_mem);

        drive_bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00010);
        exp_q.push_back(16'h5555);
        check("read_mem", data_cpu);

        drive_bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h1FFFF);
        exp_q.push_back(16'hABCD);
        check("read_io_upper_addr_ignored", data_cpu);

        // reading the IO address across an edge leaves the display alone
        clock_and_check_hex("read_no_hex_change");

        // full-word IO write with OE also low: WE has priority
        mem_drive(1'b0, 16'h0);
        cpu_drive(1'b1, 16'hBEEF);
        drive_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0FFFF);
        exp_q.push_back(16'hBEEF);
        check("write_mem_bus", data_mem);
        exp_q.push_back(16'hBEEF);
        check("write_cpu_not_driven", data_cpu);
        model_write(1'b0, 1'b0, 16'hBEEF);
        clock_and_check_hex("write_full");

        // low byte only
        cpu_drive(1'b1, 16'h1234);
        drive_bus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'h0FFFF);
        model_write(1'b1, 1'b0, 16'h1234);
        clock_and_check_hex("write_low_byte");

        // high byte only
        cpu_drive(1'b1, 16'h5678);
        drive_bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 20'h0FFFF);
        model_write(1'b0, 1'b1, 16'h5678);
        clock_and_check_hex("write_high_byte");

        // both byte enables off
        cpu_drive(1'b1, 16'h0F0F);
        drive_bus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'h0FFFF);
        clock_and_check_hex("write_no_bytes");

        // write to a neighbouring address goes to SRAM only
        cpu_drive(1'b1, 16'h9999);
        drive_bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h0FFFE);
        exp_q.push_back(16'h9999);
        check("write_miss_mem_bus", data_mem);
        clock_and_check_hex("write_miss_hex");

        // chip disabled: no write, CPU bus left to its driver
        cpu_drive(1'b1, 16'h1111);
        drive_bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0FFFF);
        exp_q.push_back(16'h1111);
        check("ce_high_cpu_not_driven", data_cpu);
        clock_and_check_hex("ce_high_hex_hold");

        // random mix of IO and non-IO writes with random byte enables
        for (int i = 0; i < 24; i++) begin
            r_d   = 16'($urandom_range(0, 16'hFFFF));
            r_ub  = 1'($urandom_range(0, 1));
            r_lb  = 1'($urandom_range(0, 1));
            r_hit = ($urandom_range(0, 3) != 0);
            r_a   = r_hit ? {4'($urandom_range(0, 15)), 16'hFFFF}
                          : 20'($urandom_range(0, 20'hFFFFE) & 20'hFFFFE);
            cpu_drive(1'b1, r_d);
            drive_bus(1'b0, 1'b1, 1'b0, r_ub, r_lb, r_a);
            if (r_hit) model_write(r_ub, r_lb, r_d);
            exp_q.push_back(r_d);
            check("rand_mem_bus", data_mem);
            clock_and_check_hex("rand_hex");
        end

        // reset again with the chip idle
        cpu_drive(1'b0, 16'h0);
        drive_bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'h0);
        reset = 1'b0;
        hex_model = 16'h0000;
        clock_and_check_hex("reset_again");
        reset = 1'b1;

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expectations: observed=%0d expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
